// File: rtl/sram_dump_reader_if.sv
// sram_dump_reader_if
// Bundles the bridge-side read port, the SRAM arbiter read port and the
// status outputs of sram_dump_reader.
//   slave  modport : the reader block itself
//   master modport : whoever drives requests / models the SRAM (bench, top level)
// Signals:
//   dumping         file controller busy (non-idle)
//   bridge_rd       one-cycle read strobe from the APF bridge
//   bridge_addr     byte address of the bridge read
//   bridge_rd_data  returned read word
//   bridge_rd_valid one-cycle pulse qualifying bridge_rd_data
//   sram_addr       halfword address to the SRAM arbiter
//   sram_rd         one-cycle SRAM read strobe
//   sram_rd_data    SRAM read data (valid SRAM_WAIT cycles after sram_rd)
//   overrun         sticky "request dropped while busy" flag
//   words_served    words returned since dumping last rose
interface sram_dump_reader_if;
  logic        dumping;
  logic        bridge_rd;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_rd_data;
  logic        bridge_rd_valid;
  logic [15:0] sram_addr;
  logic        sram_rd;
  logic [15:0] sram_rd_data;
  logic        overrun;
  logic [14:0] words_served;

  modport slave (
    input  dumping,
    input  bridge_rd,
    input  bridge_addr,
    input  sram_rd_data,
    output bridge_rd_data,
    output bridge_rd_valid,
    output sram_addr,
    output sram_rd,
    output overrun,
    output words_served
  );

  modport master (
    output dumping,
    output bridge_rd,
    output bridge_addr,
    output sram_rd_data,
    input  bridge_rd_data,
    input  bridge_rd_valid,
    input  sram_addr,
    input  sram_rd,
    input  overrun,
    input  words_served
  );
endinterface

// File: rtl/sram_dump_reader.sv
// sram_dump_reader
// Serves 32-bit APF bridge reads of a save-RAM dump window out of a 16-bit
// SRAM. Each in-window word costs two SRAM halfword reads (high half first),
// which are packed and returned with a one-cycle valid pulse. Out-of-window
// reads return zero after one cycle without touching the SRAM.
// Ports:
//   clk    sole clock, posedge
//   reset  synchronous, active-high
//   bus    sram_dump_reader_if.slave (bridge port, SRAM port, status)
// Parameters:
//   SRAM_WAIT   cycles from sram_rd to sram_rd_data valid (1..7)
//   DUMP_BYTES  dump window length in bytes
//   BASE_NIBBLE bridge_addr[31:28] value that selects this block
// Build option:
//   SRAM_DUMP_BYTESWAP_EN  when defined, the two bytes of every halfword are
//                          swapped before packing into the returned word.
module sram_dump_reader #(
  parameter int unsigned SRAM_WAIT   = 2,
  parameter logic [31:0] DUMP_BYTES  = 32'h0002_0000,
  parameter logic [3:0]  BASE_NIBBLE = 4'h2
) (
  input logic               clk,
  input logic               reset,
  sram_dump_reader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ_HI = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_READ_LO = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_RESPOND = 3'd5
  } state_t;

  // A wait state lasts SRAM_WAIT cycles: load SRAM_WAIT-1, leave at zero.
  localparam logic [2:0] WAIT_LOAD = 3'(SRAM_WAIT - 1);

  // Optional byte swap inside a halfword before it is packed.
  function automatic logic [15:0] hw_order(input logic [15:0] hw);
`ifdef SRAM_DUMP_BYTESWAP_EN
    return {hw[7:0], hw[15:8]};
`else
    return hw;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] hw_addr_q, hw_addr_d;
  logic [15:0] hi_q, hi_d;
  logic [15:0] sram_addr_q, sram_addr_d;
  logic        sram_rd_q, sram_rd_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        overrun_q, overrun_d;
  logic [14:0] words_q, words_d;
  logic        dumping_q, dumping_d;

  logic        hit_s;
  logic        in_window_s;
  logic        dump_rise_s;
  logic [15:0] req_hw_s;
  logic        addr_lsb_unused;

  // Byte-lane bits of the bridge address never matter: reads are word aligned.
  assign addr_lsb_unused = ^bus.bridge_addr[1:0];

  assign hit_s       = bus.bridge_rd & bus.dumping & (bus.bridge_addr[31:28] == BASE_NIBBLE);
  assign in_window_s = ({4'h0, bus.bridge_addr[27:2], 2'b00} < DUMP_BYTES);
  assign req_hw_s    = {bus.bridge_addr[16:2], 1'b0};
  assign dump_rise_s = bus.dumping & ~dumping_q;

  // Next-state, SRAM strobe, response packing and status counters.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hw_addr_d   = hw_addr_q;
    hi_d        = hi_q;
    sram_addr_d = sram_addr_q;
    sram_rd_d   = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    dumping_d   = bus.dumping;

    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          if (in_window_s) begin
            state_d     = ST_READ_HI;
            hw_addr_d   = req_hw_s;
            sram_addr_d = req_hw_s;
            sram_rd_d   = 1'b1;
          end else begin
            state_d    = ST_RESPOND;
            rd_data_d  = 32'h0000_0000;
            rd_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ_HI: begin
        state_d = ST_WAIT_HI;
        cnt_d   = WAIT_LOAD;
      end
      ST_WAIT_HI: begin
        if (cnt_q == 3'd0) begin
          // High halfword is on the bus during the last wait cycle.
          state_d     = ST_READ_LO;
          hi_d        = hw_order(bus.sram_rd_data);
          sram_addr_d = hw_addr_q + 16'd1;
          sram_rd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_READ_LO: begin
        state_d = ST_WAIT_LO;
        cnt_d   = WAIT_LOAD;
      end
      ST_WAIT_LO: begin
        if (cnt_q == 3'd0) begin
          state_d    = ST_RESPOND;
          rd_data_d  = {hi_q, hw_order(bus.sram_rd_data)};
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fresh dump session clears the status; that wins over any update.
    if (dump_rise_s) begin
      overrun_d = 1'b0;
    end else if (hit_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    if (dump_rise_s) begin
      words_d = 15'h0000;
    end else if (rd_valid_d && (words_q != 15'h7FFF)) begin
      words_d = words_q + 15'h0001;
    end else begin
      words_d = words_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      hw_addr_q   <= 16'h0000;
      hi_q        <= 16'h0000;
      sram_addr_q <= 16'h0000;
      sram_rd_q   <= 1'b0;
      rd_data_q   <= 32'h0000_0000;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      words_q     <= 15'h0000;
      dumping_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hw_addr_q   <= hw_addr_d;
      hi_q        <= hi_d;
      sram_addr_q <= sram_addr_d;
      sram_rd_q   <= sram_rd_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overrun_q   <= overrun_d;
      words_q     <= words_d;
      dumping_q   <= dumping_d;
    end
  end

  assign bus.bridge_rd_data  = rd_data_q;
  assign bus.bridge_rd_valid = rd_valid_q;
  assign bus.sram_addr       = sram_addr_q;
  assign bus.sram_rd         = sram_rd_q;
  assign bus.overrun         = overrun_q;
  assign bus.words_served    = words_q;

endmodule

// File: tb/tb_sram_dump_reader.sv
// Bench for sram_dump_reader: directed scenarios plus randomized reads,
// checked against a word-level reference of the dump window.
module tb_sram_dump_reader;
  localparam int          W   = 2;
  localparam logic [31:0] DB  = 32'h0002_0000;
  localparam logic [3:0]  BN  = 4'h2;
  localparam int          WIN = 2 * W + 8;

  logic clk = 1'b0;
  logic reset;

  sram_dump_reader_if bus_if();

  sram_dump_reader #(
    .SRAM_WAIT  (W),
    .DUMP_BYTES (DB),
    .BASE_NIBBLE(BN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_words = 0;
  logic exp_overrun = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SRAM contents: two fixed marker halfwords, otherwise address xor key.
  logic [15:0] key = 16'h0000;
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0100) return 16'h1234;
    else if (a == 16'h0101) return 16'h5678;
    else return a ^ key;
  endfunction

  function automatic logic [15:0] ref_order(input logic [15:0] h);
`ifdef SRAM_DUMP_BYTESWAP_EN
    return {h[7:0], h[15:8]};
`else
    return h;
`endif
  endfunction

  function automatic bit ref_in_window(input logic [31:0] a);
    logic [31:0] off;
    off = {4'h0, a[27:0]} & 32'hFFFF_FFFC;
    return off < DB;
  endfunction

  function automatic logic [15:0] ref_hw(input logic [31:0] a);
    logic [31:0] off;
    off = {4'h0, a[27:0]} & 32'hFFFF_FFFC;
    return off[16:1];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [15:0] hw;
    if (!ref_in_window(a)) return 32'h0000_0000;
    hw = ref_hw(a);
    return {ref_order(mem_val(hw)), ref_order(mem_val(hw + 16'd1))};
  endfunction

  // SRAM model: data for a strobe seen in cycle c is driven only in cycle c+W.
  logic        hist_v [0:7];
  logic [15:0] hist_a [0:7];
  int          sram_pulses = 0;
  int          valid_pulses = 0;
  logic [15:0] sram_seen [$];

  always @(negedge clk) begin
    for (int k = 7; k > 0; k--) begin
      hist_v[k] = hist_v[k-1];
      hist_a[k] = hist_a[k-1];
    end
    hist_v[0] = bus_if.sram_rd;
    hist_a[0] = bus_if.sram_addr;
    if (bus_if.sram_rd === 1'b1) begin
      sram_pulses++;
      sram_seen.push_back(bus_if.sram_addr);
    end
    if (bus_if.bridge_rd_valid === 1'b1) valid_pulses++;
    bus_if.sram_rd_data = (hist_v[W] === 1'b1) ? mem_val(hist_a[W]) : 16'hBAD0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_dumping(input logic v);
    if (v && !bus_if.dumping) begin
      exp_words   = 0;
      exp_overrun = 1'b0;
    end
    bus_if.dumping = v;
    repeat (3) tick();
  endtask

  // One bridge read with the FSM idle; checks response, latency and SRAM traffic.
  task automatic do_read(input string tag, input logic [31:0] a, input bit drop_mid);
    bit          accepted;
    bit          inwin;
    int          sp0, vp0, first_lat;
    logic [31:0] got;
    logic [31:0] exp_d;
    accepted  = (bus_if.dumping === 1'b1) && (a[31:28] == BN);
    inwin     = ref_in_window(a);
    exp_d     = ref_word(a);
    sp0       = sram_pulses;
    vp0       = valid_pulses;
    first_lat = -1;
    got       = 32'hxxxx_xxxx;
    sram_seen.delete();
    bus_if.bridge_addr = a;
    bus_if.bridge_rd   = 1'b1;
    for (int n = 1; n <= WIN; n++) begin
      tick();
      bus_if.bridge_rd = 1'b0;
      if (drop_mid && n == 2) bus_if.dumping = 1'b0;
      if (bus_if.bridge_rd_valid === 1'b1 && first_lat < 0) begin
        first_lat = n;
        got       = bus_if.bridge_rd_data;
      end
    end
    tick();
    if (accepted) begin
      if (exp_words < 32'h7FFF) exp_words++;
      check_eq({tag, "_data"}, got, exp_d);
      check_eq({tag, "_lat"}, 32'(first_lat), inwin ? 32'(2 * W + 3) : 32'd1);
      check_eq({tag, "_valids"}, 32'(valid_pulses - vp0), 32'd1);
      check_eq({tag, "_hold"}, bus_if.bridge_rd_data, exp_d);
      check_eq({tag, "_srams"}, 32'(sram_pulses - sp0), inwin ? 32'd2 : 32'd0);
      if (inwin && sram_seen.size() == 2) begin
        check_eq({tag, "_addr_hi"}, {16'h0, sram_seen[0]}, {16'h0, ref_hw(a)});
        check_eq({tag, "_addr_lo"}, {16'h0, sram_seen[1]}, {16'h0, ref_hw(a) + 16'd1});
      end
    end else begin
      check_eq({tag, "_valids"}, 32'(valid_pulses - vp0), 32'd0);
      check_eq({tag, "_srams"}, 32'(sram_pulses - sp0), 32'd0);
    end
    check_eq({tag, "_overrun"}, {31'h0, bus_if.overrun}, {31'h0, exp_overrun});
    check_eq({tag, "_words"}, {17'h0, bus_if.words_served}, 32'(exp_words));
  endtask

  initial begin
    int          sp0, vp0;
    logic [3:0]  nib;
    logic [27:0] off;
    bus_if.dumping     = 1'b0;
    bus_if.bridge_rd   = 1'b0;
    bus_if.bridge_addr = 32'h0000_0000;
    reset              = 1'b1;
    repeat (3) tick();
    check_eq("rst_data", bus_if.bridge_rd_data, 32'h0);
    check_eq("rst_valid", {31'h0, bus_if.bridge_rd_valid}, 32'h0);
    check_eq("rst_sram_rd", {31'h0, bus_if.sram_rd}, 32'h0);
    check_eq("rst_sram_addr", {16'h0, bus_if.sram_addr}, 32'h0);
    check_eq("rst_overrun", {31'h0, bus_if.overrun}, 32'h0);
    check_eq("rst_words", {17'h0, bus_if.words_served}, 32'h0);
    reset = 1'b0;
    tick();
    set_dumping(1'b1);

    // Basic in-window, out-of-window and marker reads.
    do_read("basic", 32'h2000_0008, 1'b0);
    do_read("oow", 32'h2002_0000, 1'b0);
    do_read("edge_last", 32'h2001_FFFF, 1'b0);
    do_read("marker", 32'h2000_0200, 1'b0);

    // Ignored requests: dumping low, then foreign nibble.
    set_dumping(1'b0);
    do_read("nodump", 32'h2000_0000, 1'b0);
    set_dumping(1'b1);
    do_read("nibble", 32'h3000_0000, 1'b0);

    // Dumping falling mid-transaction still completes.
    do_read("dropmid", 32'h2000_0040, 1'b1);
    set_dumping(1'b1);
    check_eq("dropmid_words_clr", {17'h0, bus_if.words_served}, 32'h0);

    // Overrun: second request two cycles into the first.
    sp0 = sram_pulses;
    vp0 = valid_pulses;
    bus_if.bridge_addr = 32'h2000_0008;
    bus_if.bridge_rd   = 1'b1;
    tick();
    bus_if.bridge_rd = 1'b0;
    tick();
    bus_if.bridge_addr = 32'h2000_0020;
    bus_if.bridge_rd   = 1'b1;
    tick();
    bus_if.bridge_rd = 1'b0;
    repeat (WIN) tick();
    exp_words++;
    exp_overrun = 1'b1;
    check_eq("ovr_valids", 32'(valid_pulses - vp0), 32'd1);
    check_eq("ovr_srams", 32'(sram_pulses - sp0), 32'd2);
    check_eq("ovr_data", bus_if.bridge_rd_data, ref_word(32'h2000_0008));
    check_eq("ovr_flag", {31'h0, bus_if.overrun}, 32'h1);
    set_dumping(1'b0);
    check_eq("ovr_sticky", {31'h0, bus_if.overrun}, 32'h1);
    set_dumping(1'b1);
    check_eq("ovr_clear", {31'h0, bus_if.overrun}, 32'h0);
    check_eq("ovr_words_clr", {17'h0, bus_if.words_served}, 32'h0);

    // Reset during WAIT_LO, together with a new strobe: no response at all.
    vp0 = valid_pulses;
    bus_if.bridge_addr = 32'h2000_0008;
    bus_if.bridge_rd   = 1'b1;
    tick();
    bus_if.bridge_rd = 1'b0;
    repeat (4) tick();
    reset              = 1'b1;
    bus_if.bridge_rd   = 1'b1;
    bus_if.bridge_addr = 32'h2000_0010;
    tick();
    check_eq("midrst_sram_rd", {31'h0, bus_if.sram_rd}, 32'h0);
    check_eq("midrst_data", bus_if.bridge_rd_data, 32'h0);
    tick();
    reset            = 1'b0;
    bus_if.bridge_rd = 1'b0;
    repeat (WIN) tick();
    check_eq("midrst_valids", 32'(valid_pulses - vp0), 32'd0);
    exp_words   = 0;
    exp_overrun = 1'b0;
    do_read("after_rst", 32'h2000_0010, 1'b0);

    // Randomized reads against the reference.
    for (int i = 0; i < 40; i++) begin
      key = 16'($urandom);
      if ($urandom_range(0, 7) == 0) set_dumping(~bus_if.dumping);
      nib = ($urandom_range(0, 9) < 7) ? BN : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1:    off = 28'($urandom_range(0, 32'h0001_FFFF));
        2:       off = 28'(DB - 32'd4 + 32'($urandom_range(0, 7)));
        default: off = 28'($urandom);
      endcase
      do_read("rand", {nib, off}, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
